// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the shared 8-bit RAM bus: turns per-requester REQ/ACK
// handshakes into registered BUS_ADDR/BUS_DATA/BUS_WE cycles with round-robin ties.
module ram_bus_arbiter #(
  parameter logic [7:0] IDLE_ADDR = 8'hFF,
  parameter logic       RR_INIT   = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic [7:0] ADDR0,
  input  logic       WE0,
  input  logic [7:0] WDATA0,
  output logic       ACK0,
  output logic [7:0] RDATA0,
  input  logic       REQ1,
  input  logic [7:0] ADDR1,
  input  logic       WE1,
  input  logic [7:0] WDATA1,
  output logic       ACK1,
  output logic [7:0] RDATA1,
  output logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic [1:0] GRANT,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic       bus_we_q, bus_we_d;
  logic       drv_q, drv_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;

  logic pick_valid;
  logic pick;
  logic pick_we;

  // Handshake: a requester raises REQ with ADDR/WE/WDATA stable; they are sampled
  // only in IDLE. ACK is a one-cycle pulse in DONE (RDATA valid with it), and the
  // requester drops REQ on that edge. A REQ seen again in IDLE is a new transaction.
  assign pick_valid = REQ0 | REQ1;
  assign pick       = (REQ0 & REQ1) ? ~last_q : REQ1;
  assign pick_we    = pick ? WE1 : WE0;

  always_comb begin
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    bus_we_d   = bus_we_q;
    drv_d      = drv_q;
    wdata_d    = wdata_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    grant_d    = grant_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick ? 2'b10 : 2'b01;
          last_d     = pick;
          bus_addr_d = pick ? ADDR1 : ADDR0;
          wdata_d    = pick ? WDATA1 : WDATA0;
          bus_we_d   = pick_we;
          drv_d      = pick_we;
          state_d    = pick_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        // The RAM commits on the edge ending this cycle; release the bus with it.
        drv_d      = 1'b0;
        bus_we_d   = 1'b0;
        bus_addr_d = IDLE_ADDR;
        ack0_d     = grant_q[0];
        ack1_d     = grant_q[1];
        state_d    = DONE;
      end
      RD_ADDR: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (grant_q[1]) rdata1_d = BUS_DATA;
        else            rdata0_d = BUS_DATA;
        bus_addr_d = IDLE_ADDR;
        ack0_d     = grant_q[0];
        ack1_d     = grant_q[1];
        state_d    = DONE;
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      bus_addr_q <= IDLE_ADDR;
      bus_we_q   <= 1'b0;
      drv_q      <= 1'b0;
      wdata_q    <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
      grant_q    <= 2'b00;
      last_q     <= RR_INIT;
    end else begin
      state_q    <= state_d;
      bus_addr_q <= bus_addr_d;
      bus_we_q   <= bus_we_d;
      drv_q      <= drv_d;
      wdata_q    <= wdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end

  assign BUS_DATA  = drv_q ? wdata_q : 8'hzz;
  assign BUS_ADDR  = bus_addr_q;
  assign BUS_WE    = bus_we_q;
  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign RDATA0    = rdata0_q;
  assign RDATA1    = rdata1_q;
  assign GRANT     = grant_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed requester transactions against a 128x8
// registered-read RAM model, with a scoreboard monitor on the ACK pulses.
module tb_ram_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req   [2];
  logic       we    [2];
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];
  wire        ack0, ack1;
  wire  [7:0] rdata0, rdata1;
  wire  [7:0] bus_addr;
  wire  [7:0] bus_data;
  wire        bus_we;
  wire  [1:0] grant;
  wire  [2:0] dbg_state;

  ram_bus_arbiter dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ0      (req[0]),
    .ADDR0     (addr[0]),
    .WE0       (we[0]),
    .WDATA0    (wdata[0]),
    .ACK0      (ack0),
    .RDATA0    (rdata0),
    .REQ1      (req[1]),
    .ADDR1     (addr[1]),
    .WE1       (we[1]),
    .WDATA1    (wdata[1]),
    .ACK1      (ack1),
    .RDATA1    (rdata1),
    .BUS_ADDR  (bus_addr),
    .BUS_DATA  (bus_data),
    .BUS_WE    (bus_we),
    .GRANT     (grant),
    .DBG_STATE (dbg_state)
  );

  // 128x8 RAM at 0x00-0x7F: registered read, drives the bus the cycle after a read address.
  logic [7:0] ram_mem [128];
  logic [7:0] ram_q;
  logic       ram_drv;
  assign bus_data = ram_drv ? ram_q : 8'hzz;
  always @(posedge clk) begin
    ram_drv <= (bus_addr[7] == 1'b0) && !bus_we;
    ram_q   <= ram_mem[bus_addr[6:0]];
    if (bus_addr[7] == 1'b0 && bus_we) ram_mem[bus_addr[6:0]] <= bus_data;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int ack_cnt [2];
  logic mon_en = 1'b0;
  logic prev_we = 1'b0;
  logic [10:0] exp_q [$];  // {check_data, owner[1:0], rdata[7:0]}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void expect_ack(input int r, input logic c, input logic [7:0] d);
    exp_q.push_back({c, (r == 1) ? 2'b10 : 2'b01, d});
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else if (mon_en) begin
      if (dbg_state == 3'd0 || dbg_state == 3'd4)
        chk("idle_done_addr", {24'h0, bus_addr}, 32'hFF);
      if (bus_we) begin
        chk("we_single_cycle", {31'h0, prev_we}, 32'h0);
        chk("we_in_wr_state", {29'h0, dbg_state}, 32'h1);
        chk("wr_bus_data", {24'h0, bus_data}, {24'h0, grant[1] ? wdata[1] : wdata[0]});
      end
      prev_we = bus_we;
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack={%b,%b} expected none", ack1, ack0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("ack_owner", {30'h0, ack1, ack0}, {30'h0, e[9:8]});
          chk("grant_in_done", {30'h0, grant}, {30'h0, e[9:8]});
          if (e[10])
            chk("rdata", {24'h0, e[9] ? rdata1 : rdata0}, {24'h0, e[7:0]});
        end
        if (ack0) ack_cnt[0]++;
        if (ack1) ack_cnt[1]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 while the arbiter is in IDLE; returns in the following IDLE.
  task automatic drive(input int r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input int lat);
    int   cnt;
    logic got;
    req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
      got = (r == 1) ? ack1 : ack0;
    end
    req[r] = 1'b0;
    chk("ack_seen", {31'h0, got}, 32'h1);
    if (got && lat != 0) chk("ack_latency", cnt, lat);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
      ack_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_ack0", {31'h0, ack0}, 32'h0);
    chk("rst_ack1", {31'h0, ack1}, 32'h0);
    chk("rst_rdata0", {24'h0, rdata0}, 32'h0);
    chk("rst_rdata1", {24'h0, rdata1}, 32'h0);
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_bus_addr", {24'h0, bus_addr}, 32'hFF);
    chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);

    // Write then read back
    expect_ack(0, 1'b0, 8'h00); drive(0, 1'b1, 8'h10, 8'hA5, 2);
    expect_ack(0, 1'b1, 8'hA5); drive(0, 1'b0, 8'h10, 8'h00, 3);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    expect_ack(0, 1'b0, 8'h00);
    expect_ack(1, 1'b0, 8'h00);
    fork
      drive(0, 1'b1, 8'h20, 8'h11, 0);
      drive(1, 1'b1, 8'h21, 8'h22, 0);
    join
    expect_ack(0, 1'b1, 8'h11); drive(0, 1'b0, 8'h20, 8'h00, 3);
    expect_ack(1, 1'b1, 8'h22); drive(1, 1'b0, 8'h21, 8'h00, 3);

    // Round-robin under continuous load
    do_reset();
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    for (int i = 0; i < 4; i++) begin
      expect_ack(0, 1'b0, 8'h00);
      expect_ack(1, 1'b0, 8'h00);
    end
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b1, 8'(8'h40 + 2 * i), 8'(8'hC0 + i), 0);
      for (int j = 0; j < 4; j++) drive(1, 1'b1, 8'(8'h41 + 2 * j), 8'(8'hD0 + j), 0);
    join
    chk("rr_acks_req0", ack_cnt[0], 4);
    chk("rr_acks_req1", ack_cnt[1], 4);
    expect_ack(1, 1'b1, 8'hC3); drive(1, 1'b0, 8'h46, 8'h00, 3);
    expect_ack(0, 1'b1, 8'hD3); drive(0, 1'b0, 8'h47, 8'h00, 3);

    // Reset during RD_DATA of requester 1
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h21;
    @(posedge clk); #1;
    chk("mr_state_rd_addr", {29'h0, dbg_state}, 32'h2);
    @(posedge clk); #1;
    chk("mr_state_rd_data", {29'h0, dbg_state}, 32'h3);
    rst = 1'b1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_ack1", {31'h0, ack1}, 32'h0);
    chk("mr_bus_addr", {24'h0, bus_addr}, 32'hFF);
    chk("mr_grant", {30'h0, grant}, 32'h0);
    chk("mr_rdata1", {24'h0, rdata1}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    expect_ack(1, 1'b1, 8'h22); drive(1, 1'b0, 8'h21, 8'h00, 3);

    // Reset on the edge that commits a write
    expect_ack(0, 1'b0, 8'h00); drive(0, 1'b1, 8'h30, 8'h00, 2);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 8'h5A;
    @(posedge clk); #1;
    chk("mw_state_wr", {29'h0, dbg_state}, 32'h1);
    chk("mw_bus_we", {31'h0, bus_we}, 32'h1);
    rst = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mw_ack0", {31'h0, ack0}, 32'h0);
    chk("mw_grant", {30'h0, grant}, 32'h0);
    chk("mw_bus_we_low", {31'h0, bus_we}, 32'h0);
    chk("mw_bus_addr", {24'h0, bus_addr}, 32'hFF);
    chk("mw_committed", {24'h0, ram_mem[7'h30]}, 32'h5A);
    repeat (3) @(posedge clk);
    #1;
    expect_ack(0, 1'b1, 8'h5A); drive(0, 1'b0, 8'h30, 8'h00, 3);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Two-master arbiter that shares the single-port 128x8 data RAM (and anything else on the 8-bit bus) between the processor (requester 0) and a DMA/peripheral engine (requester 1).
- Converts a simple REQ/ACK handshake per requester into correctly timed BUS_ADDR/BUS_DATA/BUS_WE cycles.
- Honours the RAM's registered read timing (data valid on the bus one cycle after the address) and its tristate release.
- Sits between the masters and the shared bus. The RAM is unchanged.

Parameters:
- IDLE_ADDR, 8'hFF: address driven when no transaction is active. Must decode to no slave.
- RR_INIT, 1'b1: reset value of last-granted requester. The default makes requester 0 win the first tie.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- REQ0  in  1  requester 0 transaction request
- ADDR0  in  8  requester 0 address
- WE0  in  1  requester 0 write enable (1=write, 0=read)
- WDATA0  in  8  requester 0 write data
- ACK0  out  1  requester 0 completion pulse
- RDATA0  out  8  requester 0 read data, valid while ACK0=1
- REQ1, ADDR1, WE1, WDATA1, ACK1, RDATA1: same as above, for requester 1
- BUS_ADDR  out  8  shared bus address
- BUS_DATA  inout  8  shared bus data, driven only during the WR state
- BUS_WE  out  1  shared bus write enable
- GRANT  out  2  one-hot owner of the current transaction, 2'b00 when idle

Behaviour:
- All outputs are registered. Clock is CLK; reset is synchronous, active-high on RESET.
- Reset values:
  - state=IDLE, BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA=Z
  - ACK0=ACK1=0, RDATA0=RDATA1=8'h00, GRANT=2'b00, last_grant=RR_INIT
- States: IDLE, WR, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If exactly one REQ is high, grant it.
  - If both are high, grant the requester other than last_grant (round-robin).
  - On grant: latch the owner's ADDR/WE/WDATA, set GRANT, update last_grant, drive BUS_ADDR=latched address.
  - If WE: BUS_WE=1, drive BUS_DATA=WDATA, go to WR. Otherwise BUS_WE=0, go to RD_ADDR.
  - If no REQ: stay in IDLE.
- WR (1 cycle): the RAM commits on the edge ending this cycle. Then release BUS_DATA to Z, set BUS_WE=0, BUS_ADDR=IDLE_ADDR, go to DONE.
- RD_ADDR (1 cycle): address held, BUS_WE=0, BUS_DATA=Z. Go to RD_DATA.
- RD_DATA (1 cycle): slave drives BUS_DATA. On the edge ending this cycle, capture BUS_DATA into the owner's RDATA, set BUS_ADDR=IDLE_ADDR, go to DONE.
- DONE (1 cycle):
  - Owner's ACK=1, GRANT held. Non-owner's ACK and RDATA unchanged.
  - No new grant is made in this state.
  - Next state IDLE, with ACK=0 and GRANT=00.
- Latency from the REQ-sampling edge to ACK high:
  - Write: 2 edges (ACK high in the 3rd cycle).
  - Read: 3 edges (ACK high in the 4th cycle).
- Requester rules:
  - Hold REQ, ADDR, WE and WDATA stable until ACK.
  - Drop REQ on the edge where ACK is seen. A REQ still high in the following IDLE is a new transaction.
  - Inputs are only sampled in IDLE. Changes mid-transaction are ignored.
- Bus-contention rule:
  - BUS_ADDR=IDLE_ADDR in IDLE and DONE guarantees the RAM has released BUS_DATA before any WR cycle.
  - The arbiter never drives BUS_DATA outside WR.
- Reset mid-transaction:
  - Abort to the reset values; no ACK is issued.
  - A write whose WR cycle completed before reset has committed. Otherwise nothing is written.
- Address is forwarded unmodified (all 256 addresses legal). Read data from an undriven address is captured as seen, Z/X.
- A requester that re-requests continuously cannot starve the other: after each grant the other wins the next tie.

Test Plan:
- Write then read back: REQ0 write ADDR0=8'h10, WDATA0=8'hA5 → BUS_WE=1 for exactly 1 cycle, ACK0 pulse 2 edges after request. Then REQ0 read 8'h10 → RDATA0=8'hA5 with ACK0, 3 edges after request.
- Simultaneous requests after reset: REQ0 write 8'h20=8'h11, REQ1 write 8'h21=8'h22, both held → requester 0 served first, requester 1 next. Reading 8'h20/8'h21 returns 8'h11/8'h22.
- Round-robin under continuous load: both REQs re-asserted immediately after each ACK for 8 transactions → GRANT alternates 01,10,01,… and each requester gets exactly 4 ACKs.
- Bus hygiene: monitor every cycle → BUS_DATA never driven by the arbiter while BUS_WE=0. BUS_ADDR=8'hFF in every IDLE/DONE cycle. No X on BUS_DATA during WR.
- Reset mid-read: assert RESET during RD_DATA for requester 1 → no ACK1, BUS_ADDR=8'hFF, GRANT=00, RDATA1 retains 8'h00. A subsequent read completes normally.
- Reset mid-write: assert RESET during WR for 8'h30=8'h5A on the edge that would commit → memory at 8'h30 equals 8'h5A (commit coincides with the reset edge). No ACK0 is issued.
